// File: rtl/triangle_pkg.sv
`default_nettype none
// ============================================================================
// Module      : triangle_pkg
// Description : Shared class encodings and the classification helper for
//               triangle_pipe.
// Revision    : 1.0 - initial release
// ============================================================================
package triangle_pkg;

    localparam int CLASS_W = 2;

    typedef enum logic [CLASS_W-1:0] {
        CLASS_NONE        = 2'd0,
        CLASS_SCALENE     = 2'd1,
        CLASS_ISOSCELES   = 2'd2,
        CLASS_EQUILATERAL = 2'd3
    } tri_class_e;

    // Sides arrive sorted, so any equal pair is adjacent: min==mid or mid==max.
    function automatic tri_class_e classify(
        input logic is_tri,
        input logic eq_lo,
        input logic eq_hi
    );
        tri_class_e cls;
        if (!is_tri) begin
            cls = CLASS_NONE;
        end else if (eq_lo && eq_hi) begin
            cls = CLASS_EQUILATERAL;
        end else if (eq_lo || eq_hi) begin
            cls = CLASS_ISOSCELES;
        end else begin
            cls = CLASS_SCALENE;
        end
        return cls;
    endfunction

endpackage
`default_nettype wire

// File: rtl/triangle_sort3.sv
`default_nettype none
// ============================================================================
// Module      : triangle_sort3
// Description : Combinational three-input sorter, min <= mid <= max.
// Revision    : 1.0 - initial release
// ============================================================================
module triangle_sort3 #(
    parameter int W = 8
) (
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    input  logic [W-1:0] c_i,
    output logic [W-1:0] min_o,
    output logic [W-1:0] mid_o,
    output logic [W-1:0] max_o
);

    logic [W-1:0] lo_ab;
    logic [W-1:0] hi_ab;
    logic [W-1:0] hi_lc;

    always_comb begin
        lo_ab = (a_i < b_i) ? a_i : b_i;
        hi_ab = (a_i < b_i) ? b_i : a_i;
        min_o = (lo_ab < c_i) ? lo_ab : c_i;
        hi_lc = (lo_ab < c_i) ? c_i : lo_ab;
        mid_o = (hi_ab < hi_lc) ? hi_ab : hi_lc;
        max_o = (hi_ab < hi_lc) ? hi_lc : hi_ab;
    end

endmodule
`default_nettype wire

// File: rtl/triangle_pipe.sv
`default_nettype none
// ============================================================================
// Module      : triangle_pipe
// Description : 3-stage triangle classifier (sort, sum/compare, classify) with
//               valid/ready flow control and a saturating triangle counter.
//               Define TRIANGLE_RIGHT_EN to enable the right-triangle flag.
// Revision    : 1.0 - initial release
// ============================================================================
module triangle_pipe
    import triangle_pkg::*;
#(
    parameter int W     = 8,
    parameter int CNT_W = 16
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               IN_VALID,
    output logic               IN_READY,
    input  logic [W-1:0]       A,
    input  logic [W-1:0]       B,
    input  logic [W-1:0]       C,
    output logic               OUT_VALID,
    input  logic               OUT_READY,
    output logic [CLASS_W-1:0] OUT_CLASS,
    output logic               OUT_RIGHT,
    output logic [CNT_W-1:0]   TRI_CNT
);

    logic [W-1:0] srt_min;
    logic [W-1:0] srt_mid;
    logic [W-1:0] srt_max;

    logic         s1_valid_q;
    logic [W-1:0] s1_min_q;
    logic [W-1:0] s1_mid_q;
    logic [W-1:0] s1_max_q;

    logic         s2_valid_q;
    logic [W:0]   s2_sum_q,  s2_sum_d;
    logic [W-1:0] s2_max_q;
    logic         s2_eq_lo_q, s2_eq_lo_d;
    logic         s2_eq_hi_q, s2_eq_hi_d;
    logic         s2_zero_q,  s2_zero_d;

`ifdef TRIANGLE_RIGHT_EN
    logic [2*W:0] min_x;
    logic [2*W:0] mid_x;
    logic [2*W:0] max_x;
    logic [2*W:0] s2_sq_sum_q, s2_sq_sum_d;
    logic [2*W:0] s2_max_sq_q, s2_max_sq_d;
`endif

    logic             tri_ok;
    logic             out_valid_q;
    tri_class_e       out_class_q, out_class_d;
    logic             out_right_q, out_right_d;
    logic [CNT_W-1:0] tri_cnt_q,   tri_cnt_d;
    logic             advance;

    assign advance   = !out_valid_q || OUT_READY;
    assign IN_READY  = advance;
    assign OUT_VALID = out_valid_q;
    assign OUT_CLASS = out_class_q;
    assign OUT_RIGHT = out_right_q;
    assign TRI_CNT   = tri_cnt_q;

    triangle_sort3 #(
        .W (W)
    ) u_sort (
        .a_i   (A),
        .b_i   (B),
        .c_i   (C),
        .min_o (srt_min),
        .mid_o (srt_mid),
        .max_o (srt_max)
    );

    always_comb begin
        s2_sum_d   = {1'b0, s1_min_q} + {1'b0, s1_mid_q};
        s2_eq_lo_d = (s1_min_q == s1_mid_q);
        s2_eq_hi_d = (s1_mid_q == s1_max_q);
        s2_zero_d  = (s1_min_q == '0);
`ifdef TRIANGLE_RIGHT_EN
        min_x       = {{(W+1){1'b0}}, s1_min_q};
        mid_x       = {{(W+1){1'b0}}, s1_mid_q};
        max_x       = {{(W+1){1'b0}}, s1_max_q};
        s2_sq_sum_d = min_x * min_x + mid_x * mid_x;
        s2_max_sq_d = max_x * max_x;
`endif

        // Sum is W+1 bits wide, so the strict compare cannot be fooled by overflow.
        tri_ok      = (s2_sum_q > {1'b0, s2_max_q}) && !s2_zero_q;
        out_class_d = s2_valid_q ? classify(tri_ok, s2_eq_lo_q, s2_eq_hi_q) : CLASS_NONE;
`ifdef TRIANGLE_RIGHT_EN
        out_right_d = s2_valid_q && tri_ok && (s2_sq_sum_q == s2_max_sq_q);
`else
        out_right_d = 1'b0;
`endif

        tri_cnt_d = tri_cnt_q;
        if (out_valid_q && OUT_READY && (out_class_q != CLASS_NONE) && (tri_cnt_q != '1)) begin
            tri_cnt_d = tri_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            s1_valid_q  <= 1'b0;
            s1_min_q    <= '0;
            s1_mid_q    <= '0;
            s1_max_q    <= '0;
            s2_valid_q  <= 1'b0;
            s2_sum_q    <= '0;
            s2_max_q    <= '0;
            s2_eq_lo_q  <= 1'b0;
            s2_eq_hi_q  <= 1'b0;
            s2_zero_q   <= 1'b0;
`ifdef TRIANGLE_RIGHT_EN
            s2_sq_sum_q <= '0;
            s2_max_sq_q <= '0;
`endif
            out_valid_q <= 1'b0;
            out_class_q <= CLASS_NONE;
            out_right_q <= 1'b0;
            tri_cnt_q   <= '0;
        end else begin
            tri_cnt_q <= tri_cnt_d;
            if (advance) begin
                s1_valid_q  <= IN_VALID;
                s1_min_q    <= srt_min;
                s1_mid_q    <= srt_mid;
                s1_max_q    <= srt_max;
                s2_valid_q  <= s1_valid_q;
                s2_sum_q    <= s2_sum_d;
                s2_max_q    <= s1_max_q;
                s2_eq_lo_q  <= s2_eq_lo_d;
                s2_eq_hi_q  <= s2_eq_hi_d;
                s2_zero_q   <= s2_zero_d;
`ifdef TRIANGLE_RIGHT_EN
                s2_sq_sum_q <= s2_sq_sum_d;
                s2_max_sq_q <= s2_max_sq_d;
`endif
                out_valid_q <= s2_valid_q;
                out_class_q <= out_class_d;
                out_right_q <= out_right_d;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_triangle_pipe.sv
`default_nettype none
// ============================================================================
// Module      : tb_triangle_pipe
// Description : Directed self-checking bench for triangle_pipe (W=8) plus a
//               CNT_W=2 instance for counter saturation.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_triangle_pipe;

`ifdef TRIANGLE_RIGHT_EN
    localparam bit RIGHT_ON = 1'b1;
`else
    localparam bit RIGHT_ON = 1'b0;
`endif

    logic        CLK;
    logic        RST;
    logic        IN_VALID;
    logic        IN_READY;
    logic [7:0]  A, B, C;
    logic        OUT_VALID;
    logic        OUT_READY;
    logic [1:0]  OUT_CLASS;
    logic        OUT_RIGHT;
    logic [15:0] TRI_CNT;

    logic        sat_in_ready;
    logic        sat_out_valid;
    logic [1:0]  sat_out_class;
    logic        sat_out_right;
    logic [1:0]  sat_tri_cnt;

    int n_cmp = 0;
    int n_err = 0;

    logic [7:0] va [8];
    logic [7:0] vb [8];
    logic [7:0] vc [8];
    int         ve [8];
    bit         vr [8];
    int         cnt2_log [16];

    triangle_pipe #(.W(8), .CNT_W(16)) u_dut (
        .CLK       (CLK),
        .RST       (RST),
        .IN_VALID  (IN_VALID),
        .IN_READY  (IN_READY),
        .A         (A),
        .B         (B),
        .C         (C),
        .OUT_VALID (OUT_VALID),
        .OUT_READY (OUT_READY),
        .OUT_CLASS (OUT_CLASS),
        .OUT_RIGHT (OUT_RIGHT),
        .TRI_CNT   (TRI_CNT)
    );

    triangle_pipe #(.W(8), .CNT_W(2)) u_dut_sat (
        .CLK       (CLK),
        .RST       (RST),
        .IN_VALID  (IN_VALID),
        .IN_READY  (sat_in_ready),
        .A         (A),
        .B         (B),
        .C         (C),
        .OUT_VALID (sat_out_valid),
        .OUT_READY (OUT_READY),
        .OUT_CLASS (sat_out_class),
        .OUT_RIGHT (sat_out_right),
        .TRI_CNT   (sat_tri_cnt)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
        end
    endtask

    task automatic set_vec(input int idx, input logic [7:0] a, input logic [7:0] b,
                           input logic [7:0] c, input int cls, input bit rt);
        va[idx] = a;
        vb[idx] = b;
        vc[idx] = c;
        ve[idx] = cls;
        vr[idx] = rt & RIGHT_ON;
    endtask

    task automatic do_reset();
        RST       = 1'b1;
        IN_VALID  = 1'b0;
        OUT_READY = 1'b1;
        repeat (2) @(posedge CLK);
        #1;
        RST = 1'b0;
    endtask

    // Back-to-back stream of n vectors with OUT_READY held high; pipe must be empty on entry.
    task automatic run_burst(input int n);
        for (int c = 0; c <= n + 3; c++) begin
            OUT_READY = 1'b1;
            IN_VALID  = (c < n);
            if (c < n) begin
                A = va[c];
                B = vb[c];
                C = vc[c];
            end
            #1;
            cnt2_log[c] = int'(sat_tri_cnt);
            if (c == 0) chk("burst_in_ready", IN_READY, 1);
            if (c >= 3 && c < n + 3) begin
                chk("burst_out_valid", OUT_VALID, 1);
                chk("burst_out_class", OUT_CLASS, ve[c-3]);
                chk("burst_out_right", OUT_RIGHT, vr[c-3]);
            end else begin
                chk("burst_bubble_valid", OUT_VALID, 0);
            end
            @(posedge CLK);
            #1;
        end
        IN_VALID = 1'b0;
    endtask

    initial begin
        int  si;
        int  ri;
        int  leaks;
        bit  hs;

        RST = 1'b1; IN_VALID = 1'b0; OUT_READY = 1'b1;
        A = '0; B = '0; C = '0;
        repeat (2) @(posedge CLK);
        #1;
        chk("rst_out_valid", OUT_VALID, 0);
        chk("rst_out_class", OUT_CLASS, 0);
        chk("rst_out_right", OUT_RIGHT, 0);
        chk("rst_tri_cnt",   TRI_CNT,   0);
        chk("rst_in_ready",  IN_READY,  1);
        RST = 1'b0;

        // Single right triangle: 3-cycle latency
        set_vec(0, 8'd3, 8'd4, 8'd5, 1, 1'b1);
        run_burst(1);
        chk("single_tri_cnt", TRI_CNT, 1);

        // Degenerate, zero-side and full-scale cases back to back
        do_reset();
        set_vec(0, 8'd1,   8'd2,   8'd3,   0, 1'b0);
        set_vec(1, 8'd0,   8'd5,   8'd5,   0, 1'b0);
        set_vec(2, 8'd5,   8'd0,   8'd5,   0, 1'b0);
        set_vec(3, 8'd255, 8'd255, 8'd255, 3, 1'b0);
        set_vec(4, 8'd7,   8'd7,   8'd3,   2, 1'b0);
        run_burst(5);
        chk("b2b_tri_cnt", TRI_CNT, 2);

        // Sum carry past W bits, exact-degenerate at full scale, more right triangles
        do_reset();
        set_vec(0, 8'd128, 8'd255, 8'd128, 2, 1'b0);
        set_vec(1, 8'd255, 8'd1,   8'd254, 0, 1'b0);
        set_vec(2, 8'd6,   8'd10,  8'd8,   1, 1'b1);
        set_vec(3, 8'd200, 8'd255, 8'd250, 1, 1'b0);
        set_vec(4, 8'd13,  8'd5,   8'd12,  1, 1'b1);
        run_burst(5);
        chk("edge_tri_cnt", TRI_CNT, 4);

        // Backpressure: OUT_READY low for 6 cycles while 4 triples are offered
        do_reset();
        set_vec(0, 8'd3, 8'd4, 8'd5, 1, 1'b1);
        set_vec(1, 8'd6, 8'd6, 8'd6, 3, 1'b0);
        set_vec(2, 8'd5, 8'd5, 8'd8, 2, 1'b0);
        set_vec(3, 8'd1, 8'd1, 8'd2, 0, 1'b0);
        si = 0;
        ri = 0;
        for (int c = 0; c < 14; c++) begin
            OUT_READY = (c >= 6);
            IN_VALID  = (si < 4);
            if (si < 4) begin
                A = va[si];
                B = vb[si];
                C = vc[si];
            end
            #1;
            if (c >= 3 && c <= 5) begin
                chk("stall_in_ready",  IN_READY,  0);
                chk("stall_out_valid", OUT_VALID, 1);
                chk("stall_out_class", OUT_CLASS, 1);
                chk("stall_out_right", OUT_RIGHT, RIGHT_ON);
            end
            if (OUT_VALID && OUT_READY) begin
                if (ri < 4) begin
                    chk("stall_order_class", OUT_CLASS, ve[ri]);
                    chk("stall_order_right", OUT_RIGHT, vr[ri]);
                end
                ri++;
            end
            hs = IN_VALID && IN_READY;
            @(posedge CLK);
            #1;
            if (hs) si++;
        end
        IN_VALID  = 1'b0;
        OUT_READY = 1'b1;
        chk("stall_accepted",  si, 4);
        chk("stall_delivered", ri, 4);
        chk("stall_tri_cnt",   TRI_CNT, 3);

        // Reset mid-flight: three triangles in the pipe must vanish
        do_reset();
        set_vec(0, 8'd3, 8'd3, 8'd3, 3, 1'b0);
        set_vec(1, 8'd3, 8'd4, 8'd5, 1, 1'b1);
        set_vec(2, 8'd4, 8'd4, 8'd5, 2, 1'b0);
        for (int c = 0; c < 3; c++) begin
            IN_VALID = 1'b1;
            A = va[c];
            B = vb[c];
            C = vc[c];
            @(posedge CLK);
            #1;
        end
        IN_VALID  = 1'b0;
        OUT_READY = 1'b0;
        #1;
        chk("flush_pre_valid", OUT_VALID, 1);
        RST = 1'b1;
        @(posedge CLK);
        #1;
        chk("flush_out_valid", OUT_VALID, 0);
        chk("flush_out_class", OUT_CLASS, 0);
        chk("flush_tri_cnt",   TRI_CNT,   0);
        chk("flush_in_ready",  IN_READY,  1);
        RST       = 1'b0;
        OUT_READY = 1'b1;
        leaks = 0;
        for (int c = 0; c < 6; c++) begin
            #1;
            if (OUT_VALID) leaks++;
            @(posedge CLK);
            #1;
        end
        chk("flush_leaks", leaks, 0);
        set_vec(0, 8'd2, 8'd3, 8'd4, 1, 1'b0);
        run_burst(1);
        chk("flush_after_cnt", TRI_CNT, 1);

        // Narrow counter saturates at 3
        do_reset();
        for (int i = 0; i < 5; i++) set_vec(i, 8'd2, 8'd2, 8'd3, 2, 1'b0);
        run_burst(5);
        chk("sat_cnt_1", cnt2_log[4], 1);
        chk("sat_cnt_2", cnt2_log[5], 2);
        chk("sat_cnt_3", cnt2_log[6], 3);
        chk("sat_cnt_4", cnt2_log[7], 3);
        chk("sat_cnt_5", cnt2_log[8], 3);
        chk("sat_wide_cnt", TRI_CNT, 5);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/triangle_pipe.md
TRIANGLE_PIPE -- requirements
Module: triangle_pipe

Interface
REQ-001 SHALL have parameter W, default 8, side-length width in bits (W >= 2).
REQ-002 SHALL have parameter CNT_W, default 16, width of the triangle counter.
REQ-003 SHALL have port CLK  input  1  sole clock; all state changes on rising edge.
REQ-004 SHALL have port RST  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port IN_VALID  input  1  triple on A/B/C is offered.
REQ-006 SHALL have port IN_READY  output  1  block accepts the triple this cycle.
REQ-007 SHALL have ports A, B, C  input  W each  unsigned side lengths, any order.
REQ-008 SHALL have port OUT_VALID  output  1  result is held on the outputs.
REQ-009 SHALL have port OUT_READY  input  1  consumer takes the result.
REQ-010 SHALL have port OUT_CLASS  output  2  0 NONE, 1 SCALENE, 2 ISOSCELES, 3 EQUILATERAL.
REQ-011 SHALL have port OUT_RIGHT  output  1  right-triangle flag.
REQ-012 SHALL have port TRI_CNT  output  CNT_W  count of results delivered with OUT_CLASS != NONE.

Function
REQ-013 SHALL accept a triple on a cycle with IN_VALID && IN_READY; deliver it on a cycle with OUT_VALID && OUT_READY.
REQ-014 SHALL be a 3-stage pipeline: S1 sort to MIN <= MID <= MAX; S2 form SUM = MIN + MID at W+1 bits, plus equality flags; S3 classify and register outputs.
REQ-015 SHALL give a latency of exactly 3 cycles from acceptance to OUT_VALID when no stall occurs; throughput SHALL be 1 triple per cycle.
REQ-016 SHALL drive IN_READY = !OUT_VALID || OUT_READY. All stages advance together; when IN_READY = 0 every stage holds.
REQ-017 SHALL keep OUT_VALID and all outputs stable while OUT_VALID && !OUT_READY.
REQ-018 SHALL let bubbles (invalid stage slots) advance through the pipeline, and SHALL never emit them.
REQ-019 SHALL report a triangle only if SUM > MAX with strict compare and no overflow. The degenerate case SUM == MAX, and any zero side, SHALL give NONE.
REQ-020 Given a triangle, SHALL report EQUILATERAL if all sides are equal, else ISOSCELES if any two are equal, else SCALENE.
REQ-021 SHALL increment TRI_CNT on each delivery handshake with class != NONE, saturating at 2^CNT_W-1 with no wrap.
REQ-022 SHALL preserve input order in the output; results SHALL never be dropped or duplicated.

Reset
REQ-023 While RST = 1: all stage valids SHALL be 0, OUT_VALID = 0, OUT_CLASS = 0, OUT_RIGHT = 0, TRI_CNT = 0, and IN_READY = 1.
REQ-024 SHALL discard in-flight triples when reset is asserted mid-operation; nothing from before reset SHALL appear after it.

Configuration
REQ-025 With macro TRIANGLE_RIGHT_EN defined, SHALL compute MIN^2 + MID^2 (2W+1 bits) in S2 and MAX^2 in S2, and set OUT_RIGHT = triangle && equal.
REQ-026 With TRIANGLE_RIGHT_EN undefined, SHALL tie OUT_RIGHT to 0, synthesise no multipliers, and leave latency unchanged.

Structure
REQ-027 SHALL place the class encodings (NONE, SCALENE, ISOSCELES, EQUILATERAL) and the class width constant in shared package triangle_pkg.
REQ-028 SHALL implement the S1 sort in sub-module triangle_sort3, a combinational 3-input sorter parametrised by W.

Verification (W=8, CNT_W=16 unless stated)
REQ-029 Inputs (3,4,5), OUT_READY=1 -> 3 cycles later CLASS=1; RIGHT=1 with macro, 0 without; TRI_CNT=1.
REQ-030 Back-to-back (1,2,3), (0,5,5), (5,0,5), (255,255,255), (7,7,3) -> CLASS 0,0,0,3,2 on consecutive cycles; no overflow; TRI_CNT=2.
REQ-031 4 triples sent while OUT_READY=0 for 6 cycles -> IN_READY drops once the pipe is full; outputs held stable; after release all 4 are delivered in order.
REQ-032 RST pulsed for 1 cycle with 3 triples in flight -> OUT_VALID=0 next cycle, TRI_CNT=0, the flushed triples are never emitted.
REQ-033 CNT_W=2, 5 valid triangles (2,2,3) delivered -> TRI_CNT reads 1, 2, 3, 3, 3.
